// File: rtl/cplx_div_pkg.sv
// Shared types, widths and the output saturation helper for the complex divider.
package cplx_div_pkg;

   // Package widths are sized for the default component width.
   // The divider's WIDTH parameter must match CD_WIDTH.
   localparam int CD_WIDTH = 16;
   localparam int CD_N     = 2 * CD_WIDTH + 1;
   localparam int CD_CNT_W = $clog2(CD_N);

   typedef enum logic [2:0] {
      IDLE,
      MULT,
      DIV,
      FMT,
      DONE
   } state_t;

   typedef struct packed {
      logic [CD_WIDTH-1:0] val;
      logic                flag;
   } sat_t;

   // Clamp an N-bit signed quotient into the WIDTH-bit signed range.
   // flag is set when the value had to be clamped.
   function automatic sat_t saturate(input logic signed [CD_N-1:0] v);
      sat_t                    r;
      logic signed [CD_N-1:0]  hi;
      logic signed [CD_N-1:0]  lo;
      hi = {{(CD_N-CD_WIDTH+1){1'b0}}, {(CD_WIDTH-1){1'b1}}};
      lo = {{(CD_N-CD_WIDTH+1){1'b1}}, {(CD_WIDTH-1){1'b0}}};
      if (v > hi) begin
         r.val  = {1'b0, {(CD_WIDTH-1){1'b1}}};
         r.flag = 1'b1;
      end else if (v < lo) begin
         r.val  = {1'b1, {(CD_WIDTH-1){1'b0}}};
         r.flag = 1'b1;
      end else begin
         r.val  = v[CD_WIDTH-1:0];
         r.flag = 1'b0;
      end
      return r;
   endfunction

endpackage

// File: rtl/complex_num.sv
// Complex number bus shared with the add/multiply pipeline.
interface complex_num #(parameter int WIDTH = 16);
   logic signed [WIDTH-1:0] riyal;
   logic signed [WIDTH-1:0] imag;

   modport IN  (input  riyal, input  imag);
   modport OUT (output riyal, output imag);
endinterface

// File: rtl/cplx_div_udiv_seq.sv
// Unsigned restoring divider: one quotient bit per step, MSB first.
// The divisor is held by the caller and must stay stable while stepping.
module udiv_seq #(
   parameter int NW = 33,
   parameter int DW = 32
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          load_i,
   input  logic          step_i,
   input  logic [NW-1:0] num_i,
   input  logic [DW-1:0] den_i,
   output logic [NW-1:0] quo_o
);

   logic [NW-1:0] num_q;
   logic [DW-1:0] rem_q;
   logic [NW-1:0] quo_q;

   logic [DW:0]   rem_sh;
   logic          ge;
   logic [DW-1:0] rem_nx;

   // Shift the next numerator bit into the partial remainder and trial-subtract.
   always_comb begin
      rem_sh = {rem_q, num_q[NW-1]};
      ge     = (rem_sh >= {1'b0, den_i});
      rem_nx = ge ? DW'(rem_sh - {1'b0, den_i}) : rem_sh[DW-1:0];
   end

   // Load clears the remainder and quotient; each step retires one bit.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         num_q <= '0;
         rem_q <= '0;
         quo_q <= '0;
      end else if (load_i) begin
         num_q <= num_i;
         rem_q <= '0;
         quo_q <= '0;
      end else if (step_i) begin
         num_q <= {num_q[NW-2:0], 1'b0};
         rem_q <= rem_nx;
         quo_q <= {quo_q[NW-2:0], ge};
      end
   end

   assign quo_o = quo_q;

endmodule

// File: rtl/cplx_div.sv
// Sequential complex divider: q = (a + b i) / (c + d i), truncated toward zero
// and saturated to WIDTH signed. One operation in flight at a time.
//
// state | meaning
// IDLE  | accepting operands (in_ready=1)
// MULT  | form num_re, num_im, den, signs and magnitudes
// DIV   | one restoring quotient bit per edge for re and im (skipped on zero divisor)
// FMT   | apply signs, saturate, load outputs
// DONE  | result presented until out_ready
module cplx_div
   import cplx_div_pkg::*;
#(
   parameter int WIDTH = CD_WIDTH
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   output logic        in_ready,
   complex_num.IN      a_b,
   complex_num.IN      c_d,
   output logic        out_valid,
   input  logic        out_ready,
   complex_num.OUT     q,
   output logic        div_by_zero,
   output logic        sat
);

   localparam int N  = 2 * WIDTH + 1;
   localparam int DW = 2 * WIDTH;
   localparam int CW = $clog2(N);

   state_t state_q, state_d;

   logic signed [WIDTH-1:0] a_q, b_q, c_q, d_q;
   logic [DW-1:0]           den_q;
   logic                    neg_re_q, neg_im_q;
   logic                    dz_q;
   logic [CW-1:0]           cnt_q;
   logic                    in_ready_q;
   logic [WIDTH-1:0]        q_re_q, q_im_q;
   logic                    sat_q, dz_out_q;

   logic signed [N-1:0]     ax, bx, cx, dx;
   logic signed [N-1:0]     num_re_c, num_im_c;
   logic [DW-1:0]           den_c;
   logic [N-1:0]            mag_re_c, mag_im_c;
   logic [N-1:0]            quo_re, quo_im;
   logic signed [N-1:0]     res_re_c, res_im_c;
   sat_t                    sat_re_c, sat_im_c;
   logic                    accept, last_step;

   assign accept    = in_valid && in_ready_q;
   assign last_step = (cnt_q == CW'(N - 1));

   // Cross products and divisor energy from the captured operands.
   always_comb begin
      ax       = {{(N-WIDTH){a_q[WIDTH-1]}}, a_q};
      bx       = {{(N-WIDTH){b_q[WIDTH-1]}}, b_q};
      cx       = {{(N-WIDTH){c_q[WIDTH-1]}}, c_q};
      dx       = {{(N-WIDTH){d_q[WIDTH-1]}}, d_q};
      num_re_c = ax * cx + bx * dx;
      num_im_c = bx * cx - ax * dx;
      den_c    = DW'(cx * cx + dx * dx);
      mag_re_c = num_re_c[N-1] ? -num_re_c : num_re_c;
      mag_im_c = num_im_c[N-1] ? -num_im_c : num_im_c;
   end

   // Reapply the signs to the magnitude quotients, then clamp to WIDTH.
   always_comb begin
      res_re_c = neg_re_q ? -signed'(quo_re) : signed'(quo_re);
      res_im_c = neg_im_q ? -signed'(quo_im) : signed'(quo_im);
      sat_re_c = saturate(res_re_c);
      sat_im_c = saturate(res_im_c);
   end

   udiv_seq #(.NW(N), .DW(DW)) u_div_re (
      .clk    (clk),
      .rst    (rst),
      .load_i (state_q == MULT),
      .step_i ((state_q == DIV) && !dz_q),
      .num_i  (mag_re_c),
      .den_i  (den_q),
      .quo_o  (quo_re)
   );

   udiv_seq #(.NW(N), .DW(DW)) u_div_im (
      .clk    (clk),
      .rst    (rst),
      .load_i (state_q == MULT),
      .step_i ((state_q == DIV) && !dz_q),
      .num_i  (mag_im_c),
      .den_i  (den_q),
      .quo_o  (quo_im)
   );

   // Next-state logic.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (accept) state_d = MULT;
         MULT:    state_d = DIV;
         DIV:     if (dz_q || last_step) state_d = FMT;
         FMT:     state_d = DONE;
         DONE:    if (out_ready) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // State register; in_ready is registered so it stays low during reset
   // and rises on the first edge after reset release.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= IDLE;
         in_ready_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         in_ready_q <= (state_d == IDLE);
      end
   end

   // Operand capture, product stage bookkeeping and iteration count.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         a_q      <= '0;
         b_q      <= '0;
         c_q      <= '0;
         d_q      <= '0;
         den_q    <= '0;
         neg_re_q <= 1'b0;
         neg_im_q <= 1'b0;
         dz_q     <= 1'b0;
         cnt_q    <= '0;
      end else begin
         if (state_q == IDLE && accept) begin
            a_q <= a_b.riyal;
            b_q <= a_b.imag;
            c_q <= c_d.riyal;
            d_q <= c_d.imag;
         end
         if (state_q == MULT) begin
            den_q    <= den_c;
            neg_re_q <= num_re_c[N-1];
            neg_im_q <= num_im_c[N-1];
            dz_q     <= (den_c == '0);
            cnt_q    <= '0;
         end else if (state_q == DIV) begin
            cnt_q <= cnt_q + CW'(1);
         end
      end
   end

   // Result registers change only on the FMT->DONE edge.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         q_re_q   <= '0;
         q_im_q   <= '0;
         sat_q    <= 1'b0;
         dz_out_q <= 1'b0;
      end else if (state_q == FMT) begin
         q_re_q   <= dz_q ? '0 : sat_re_c.val;
         q_im_q   <= dz_q ? '0 : sat_im_c.val;
         sat_q    <= !dz_q && (sat_re_c.flag || sat_im_c.flag);
         dz_out_q <= dz_q;
      end
   end

   assign in_ready    = in_ready_q;
   assign out_valid   = (state_q == DONE);
   assign q.riyal     = q_re_q;
   assign q.imag      = q_im_q;
   assign sat         = sat_q;
   assign div_by_zero = dz_out_q;

endmodule

// File: tb/tb_cplx_div.sv
// Self-checking bench for cplx_div: directed cases plus random operands
// checked against an integer-arithmetic reference model.
module tb_cplx_div;

   localparam int W = 16;

   logic clk = 1'b0;
   logic rst;
   logic in_valid;
   logic in_ready;
   logic out_valid;
   logic out_ready;
   logic div_by_zero;
   logic sat;

   int checks   = 0;
   int failures = 0;

   complex_num #(.WIDTH(W)) ab_if ();
   complex_num #(.WIDTH(W)) cd_if ();
   complex_num #(.WIDTH(W)) q_if ();

   cplx_div #(.WIDTH(W)) dut (
      .clk         (clk),
      .rst         (rst),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .a_b         (ab_if),
      .c_d         (cd_if),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .q           (q_if),
      .div_by_zero (div_by_zero),
      .sat         (sat)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input longint obs, input longint exp);
      checks++;
      assert (obs === exp)
      else begin
         failures++;
         $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Reference: exact complex quotient in 64-bit integers, C-style truncation.
   task automatic model(input int a, input int b, input int c, input int d,
                        output longint er, output longint ei,
                        output longint es, output longint ez);
      longint nr, ni, den, qr, qi;
      longint hi, lo;
      hi  = (64'sd1 <<< (W - 1)) - 1;
      lo  = -(64'sd1 <<< (W - 1));
      nr  = longint'(a) * c + longint'(b) * d;
      ni  = longint'(b) * c - longint'(a) * d;
      den = longint'(c) * c + longint'(d) * d;
      es  = 0;
      if (den == 0) begin
         er = 0; ei = 0; ez = 1;
      end else begin
         ez = 0;
         qr = nr / den;
         qi = ni / den;
         if (qr > hi) begin qr = hi; es = 1; end
         if (qr < lo) begin qr = lo; es = 1; end
         if (qi > hi) begin qi = hi; es = 1; end
         if (qi < lo) begin qi = lo; es = 1; end
         er = qr; ei = qi;
      end
   endtask

   task automatic wait_ready(input string tag);
      int n = 0;
      while (!in_ready && n < 100) begin
         @(posedge clk); #1;
         n++;
      end
      if (!in_ready) check({tag, "_ready_timeout"}, 0, 1);
   endtask

   task automatic do_op(input int a, input int b, input int c, input int d,
                        input int hold, input string tag);
      longint er, ei, es, ez;
      int lat;
      model(a, b, c, d, er, ei, es, ez);
      wait_ready(tag);
      ab_if.riyal = W'(a);
      ab_if.imag  = W'(b);
      cd_if.riyal = W'(c);
      cd_if.imag  = W'(d);
      in_valid    = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      check({tag, "_busy"}, longint'(in_ready), 0);
      lat = 0;
      while (!out_valid && lat < 100) begin
         @(posedge clk); #1;
         lat++;
      end
      check({tag, "_latency"}, lat, (ez != 0) ? 3 : 2 * W + 3);
      check({tag, "_re"}, longint'(q_if.riyal), er);
      check({tag, "_im"}, longint'(q_if.imag), ei);
      check({tag, "_sat"}, longint'(sat), es);
      check({tag, "_dz"}, longint'(div_by_zero), ez);
      for (int i = 0; i < hold; i++) begin
         @(posedge clk); #1;
         check({tag, "_hold_valid"}, longint'(out_valid), 1);
         check({tag, "_hold_ready"}, longint'(in_ready), 0);
         check({tag, "_hold_re"}, longint'(q_if.riyal), er);
         check({tag, "_hold_im"}, longint'(q_if.imag), ei);
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      check({tag, "_drop_valid"}, longint'(out_valid), 0);
      check({tag, "_rise_ready"}, longint'(in_ready), 1);
   endtask

   function automatic int rnd16();
      logic signed [W-1:0] v;
      v = W'($urandom);
      return int'(v);
   endfunction

   initial begin
      int stale;
      rst         = 1'b1;
      in_valid    = 1'b0;
      out_ready   = 1'b0;
      ab_if.riyal = '0;
      ab_if.imag  = '0;
      cd_if.riyal = '0;
      cd_if.imag  = '0;

      repeat (3) @(posedge clk);
      #1;
      check("rst_ready", longint'(in_ready), 0);
      check("rst_valid", longint'(out_valid), 0);
      check("rst_re", longint'(q_if.riyal), 0);
      check("rst_im", longint'(q_if.imag), 0);
      check("rst_sat", longint'(sat), 0);
      check("rst_dz", longint'(div_by_zero), 0);
      rst = 1'b0;
      @(posedge clk); #1;
      check("rel_ready", longint'(in_ready), 1);

      do_op(7, 4, 1, 2, 0, "basic");
      do_op(-7, 0, 2, 0, 0, "trunc");
      do_op(0, 0, 3, -5, 0, "zero_num");
      do_op(-32768, 0, 1, 0, 0, "min_pass");
      do_op(7, 4, 1, 2, 10, "stall");
      do_op(6, 0, 3, 0, 0, "second");
      do_op(10, 5, 0, 0, 0, "divzero");
      do_op(-32768, -32768, -1, 0, 0, "satpos");

      // Abort in the 10th DIV cycle; previous result (saturated) is still on q.
      wait_ready("abort");
      ab_if.riyal = 16'sd7;
      ab_if.imag  = 16'sd4;
      cd_if.riyal = 16'sd1;
      cd_if.imag  = 16'sd2;
      in_valid    = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (10) @(posedge clk);
      #2;
      rst = 1'b1;
      #1;
      check("abort_valid", longint'(out_valid), 0);
      check("abort_ready", longint'(in_ready), 0);
      check("abort_re", longint'(q_if.riyal), 0);
      check("abort_im", longint'(q_if.imag), 0);
      check("abort_sat", longint'(sat), 0);
      check("abort_dz", longint'(div_by_zero), 0);
      @(posedge clk); #1;
      rst = 1'b0;
      @(posedge clk); #1;
      check("abort_rel_ready", longint'(in_ready), 1);
      stale = 0;
      for (int i = 0; i < 40; i++) begin
         @(posedge clk); #1;
         if (out_valid) stale++;
      end
      check("abort_no_stale", stale, 0);
      do_op(7, 4, 1, 2, 0, "after_abort");

      // Random operands: alternate full-range and small divisors.
      for (int i = 0; i < 16; i++) begin
         int a, b, c, d;
         a = rnd16();
         b = rnd16();
         if (i % 2 == 0) begin
            c = int'($urandom_range(0, 16)) - 8;
            d = int'($urandom_range(0, 16)) - 8;
         end else begin
            c = rnd16();
            d = rnd16();
         end
         do_op(a, b, c, d, i % 3, "rand");
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
